// File: rtl/bus_master_port.sv
// Per-master serial bus port: captures one controller command, arbitrates for the
// shared bus, shifts out mode/address/data, then collects the write ack or read byte.
module bus_master_port #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        read_en_i,
   input  logic [7:0]  data_in_i,
   input  logic [13:0] addr_in_i,
   input  logic        bus_grant_i,
   input  logic        slave_ack_i,
   input  logic        rx_bit_i,
   input  logic        rx_valid_i,
   output logic        request_o,
   output logic        tx_bit_o,
   output logic        tx_valid_o,
   output logic [7:0]  data_out_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int unsigned TW      = $clog2(TIMEOUT + 1);
   localparam logic [4:0]  LAST_RD = 5'd14;
   localparam logic [4:0]  LAST_WR = 5'd22;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_SEND  = 3'd2,
      S_WACK  = 3'd3,
      S_RWAIT = 3'd4,
      S_FIN   = 3'd5,
      S_ABORT = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic          armed_q, armed_d;
   logic          rd_q, rd_d;
   logic [13:0]   addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic [2:0]    rx_cnt_q, rx_cnt_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          request_q, request_d;
   logic          tx_bit_q, tx_bit_d;
   logic          tx_valid_q, tx_valid_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [22:0]   tx_frame_s;
   logic [4:0]    last_idx_s;
   logic          tmo_hit_s;

   assign last_idx_s = rd_q ? LAST_RD : LAST_WR;
   assign tmo_hit_s  = (tmo_q == TW'(TIMEOUT - 1));

   // Next-state logic; armed only re-arms on a cycle with enable low.
   always_comb begin
      state_d    = state_q;
      armed_d    = enable_i ? armed_q : 1'b1;
      rd_d       = rd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bit_cnt_d  = bit_cnt_q;
      tmo_d      = tmo_q;
      rx_sh_d    = rx_sh_q;
      rx_cnt_d   = rx_cnt_q;
      data_out_d = data_out_q;
      case (state_q)
         S_IDLE: begin
            if (enable_i && armed_q) begin
               rd_d    = read_en_i;
               addr_d  = addr_in_i;
               wdata_d = data_in_i;
               armed_d = 1'b0;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus_grant_i) begin
               bit_cnt_d = 5'd0;
               state_d   = S_SEND;
            end else begin
               state_d = S_REQ;
            end
         end
         S_SEND: begin
            if (!bus_grant_i) begin
               state_d = S_ABORT;
            end else if (bit_cnt_q == last_idx_s) begin
               tmo_d    = '0;
               rx_cnt_d = 3'd0;
               state_d  = rd_q ? S_RWAIT : S_WACK;
            end else begin
               bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         S_WACK: begin
            if (!bus_grant_i) begin
               state_d = S_ABORT;
            end else if (slave_ack_i) begin
               state_d = S_FIN;
            end else if (tmo_hit_s) begin
               state_d = S_ABORT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_RWAIT: begin
            if (!bus_grant_i) begin
               state_d = S_ABORT;
            end else if (rx_valid_i) begin
               rx_sh_d = {rx_sh_q[6:0], rx_bit_i};
               tmo_d   = '0;
               if (rx_cnt_q == 3'd7) begin
                  data_out_d = {rx_sh_q[6:0], rx_bit_i};
                  state_d    = S_FIN;
               end else begin
                  rx_cnt_d = rx_cnt_q + 3'd1;
               end
            end else if (tmo_hit_s) begin
               state_d = S_ABORT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_FIN:   state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      tx_frame_s = {rd_q, addr_q, wdata_q} << bit_cnt_d;
      request_d  = (state_d == S_REQ) || (state_d == S_SEND) ||
                   (state_d == S_WACK) || (state_d == S_RWAIT);
      tx_valid_d = (state_d == S_SEND);
      tx_bit_d   = (state_d == S_SEND) ? tx_frame_s[22] : 1'b0;
      done_d     = (state_d == S_FIN);
      err_d      = (state_d == S_ABORT);
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         armed_q    <= 1'b1;
         rd_q       <= 1'b0;
         addr_q     <= 14'd0;
         wdata_q    <= 8'd0;
         bit_cnt_q  <= 5'd0;
         tmo_q      <= '0;
         rx_sh_q    <= 8'd0;
         rx_cnt_q   <= 3'd0;
         data_out_q <= 8'd0;
         request_q  <= 1'b0;
         tx_bit_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         bit_cnt_q  <= bit_cnt_d;
         tmo_q      <= tmo_d;
         rx_sh_q    <= rx_sh_d;
         rx_cnt_q   <= rx_cnt_d;
         data_out_q <= data_out_d;
         request_q  <= request_d;
         tx_bit_q   <= tx_bit_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign request_o  = request_q;
   assign tx_bit_o   = tx_bit_q;
   assign tx_valid_o = tx_valid_q;
   assign data_out_o = data_out_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule
